// File: rtl/sync_fifo_pkg.sv
// Purpose: shared defaults and helpers for the sync_fifo byte buffer.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
//
// Contents: default DATA_W / DEPTH, and ptr_width() which returns the
// pointer width (address bits plus one wrap bit) for a given depth.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Pointer width = address width + 1 wrap bit used to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Purpose: DEPTH x DATA_W register array backing the sync_fifo storage.
// Latency: write lands on the rising edge; read is combinational from raddr.
// Backpressure: none; the caller decides when we is asserted.
//
// Ports: clk (write clock), we/waddr/wdata (synchronous write port),
//        raddr/rdata (asynchronous read port). Contents are never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with registered read data and full/empty flags.
// Latency: write visible to a read from the next cycle; rdata valid 1 cycle after an accepted read.
// Backpressure: writes while full and reads while empty are silently dropped.
//
// Ports: clk, rst_n (async active-low), wr_en/wdata (push), rd_en (pop),
//        rdata (registered head data), empty, full.
// Optional: define SYNC_FIFO_ASSERT_EN to compile in simulation-only
//           overflow/underflow/flag-consistency assertions.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Flags decode registered pointers only, so they never depend
  // combinationally on wr_en / rd_en.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdata  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        // Head is captured at the same edge the pointer advances, so an
        // entry written this cycle is never bypassed to rdata.
        rdata  <= mem_rdata;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef SYNC_FIFO_ASSERT_EN
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full))
    else $error("sync_fifo: write attempted while full");
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty))
    else $error("sync_fifo: read attempted while empty");
  a_flags_exclusive : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty))
    else $error("sync_fifo: full and empty both high");
`else
  // Assertions not compiled in; functional behaviour is identical.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          full;

  sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of bytes plus the last popped value.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rdata = '0;
  bit            m_wa;
  bit            m_ra;
  int            n_wr_acc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_rdata = '0;
    end else begin
      m_wa = wr_en && (q.size() != DEPTH);
      m_ra = rd_en && (q.size() != 0);
      if (m_ra) m_rdata = q.pop_front();
      if (m_wa) begin
        q.push_back(wdata);
        n_wr_acc++;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full",  {31'd0, full},  {31'd0, q.size() == DEPTH});
    chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
  end

  task automatic drive(input bit w, input bit r, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    wdata = d;
  endtask

  task automatic mid_cycle_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full",  {31'd0, full},  32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset pulse between clock edges, then again with data held.
    mid_cycle_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h30 + i));
    drive(1'b0, 1'b0, '0);
    chk("five_held_nonempty", {31'd0, empty}, 32'd0);
    mid_cycle_reset();

    // Basic single write/read.
    drive(1'b1, 1'b0, 8'hA5);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("basic_rdata", {24'd0, rdata}, 32'hA5);
    chk("basic_empty", {31'd0, empty}, 32'd1);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i));
    drive(1'b1, 1'b0, 8'hFF);
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      if (i > 0) chk("drain_order", {24'd0, rdata}, 32'(i - 1));
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("drain_last", {24'd0, rdata}, 32'h0F);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Underflow: reads on empty are ignored.
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("underflow_rdata", {24'd0, rdata}, 32'h0F);
    chk("underflow_empty", {31'd0, empty}, 32'd1);

    // Simultaneous with 3 entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, DW'(8'h10 + i));
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, DW'(8'h20 + i));
    drive(1'b0, 1'b0, 8'h00);
    chk("simul_rdata", {24'd0, rdata}, 32'h26);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("simul_tail", {24'd0, rdata}, 32'h29);

    // Simultaneous from empty: only the write lands.
    drive(1'b1, 1'b1, 8'h5C);
    drive(1'b0, 1'b0, 8'h00);
    chk("simul_empty_flag", {31'd0, empty}, 32'd0);
    chk("simul_empty_rdata", {24'd0, rdata}, 32'h29);
    drive(1'b0, 1'b1, 8'h00);

    // Simultaneous from full: only the read lands.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(8'h40 + i));
    drive(1'b1, 1'b1, 8'hEE);
    drive(1'b0, 1'b0, 8'h00);
    chk("simul_full_flag", {31'd0, full}, 32'd0);
    chk("simul_full_rdata", {24'd0, rdata}, 32'h40);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'h00);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, DW'($urandom));
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    chk("final_empty", {31'd0, empty}, 32'd1);
    chk("wrap_count_ge3", {31'd0, n_wr_acc >= 3 * DEPTH}, 32'd1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, first-in-first-out byte buffer with registered read data and full/empty status flags. It decouples a producer and a consumer that run on the same clock domain. It is a generic datapath utility, instantiated wherever short-term byte buffering is required.

Parameters:
DATA_W, 8, width of each stored word in bits.
DEPTH, 16, number of entries; must be a power of two and at least 2.
ADDR_W, $clog2(DEPTH), derived storage address width; not overridden by users.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr_en  input  1  write request; wdata is pushed when it is accepted.
rd_en  input  1  read request; the head entry is popped when it is accepted.
wdata  input  DATA_W  write data.
rdata  output  DATA_W  registered read data.
empty  output  1  high when the FIFO holds 0 entries.
full  output  1  high when the FIFO holds DEPTH entries.

Behaviour:
- Reset: asynchronous, active-low, applied immediately and released synchronously to clk. While rst_n=0: read and write pointers = 0, rdata = 0, empty = 1, full = 0. Storage contents are not cleared.
- Pointers: write and read pointers are ADDR_W+1 bits wide; the MSB is a wrap bit.
- empty = (wr_ptr == rd_ptr).
- full = (addresses equal) and (wrap bits differ).
- Both flags are decoded from registered pointers and change only after a clock edge or reset; no combinational path from wr_en/rd_en to the flags.
- Write accepted = wr_en && !full. On acceptance, mem[wr_addr] <= wdata and wr_ptr increments. A write while full is silently dropped; no state changes.
- Read accepted = rd_en && !empty. On acceptance, rdata <= mem[rd_addr] at the same edge, so data is visible 1 cycle after the request, and rd_ptr increments.
- A read while empty is ignored; rdata holds its previous value.
- rdata holds its value in every cycle without an accepted read.
- Simultaneous wr_en and rd_en, neither full nor empty: both are accepted, occupancy is unchanged, and the flags are unchanged.
- Simultaneous requests when empty: only the write is accepted; the next cycle has empty=0.
- Simultaneous requests when full: only the read is accepted; the next cycle has full=0.
- Wrap-around: address bits wrap from DEPTH-1 to 0 and the wrap bit toggles. Order is preserved across the wrap.
- No bypass path: data written in cycle N is readable from cycle N+1 onward.
- Occupancy after any sequence = accepted writes - accepted reads, always within 0..DEPTH.

Optional Feature:
SYNC_FIFO_ASSERT_EN
- Defined: simulation-only assertions are compiled in.
  - Error on wr_en while full (overflow attempt).
  - Error on rd_en while empty (underflow attempt).
  - Error if full and empty are both high.
  - All assertions are disabled while rst_n=0.
- Undefined: no assertion code is present. Functional behaviour is identical in both cases.

Decomposition:
- Package sync_fifo_pkg holds the default DATA_W and DEPTH constants and a helper function computing the pointer width (ADDR_W+1).
- One natural sub-module: sync_fifo_mem, a DEPTH x DATA_W register array.
  - One synchronous write port: we, waddr, wdata.
  - One asynchronous read address port (raddr) feeding the rdata register in the top level.
- Pointer and flag logic stays in sync_fifo.

Test Plan:
- Reset: pulse rst_n low mid-cycle with no clock edge -> immediately empty=1, full=0, rdata=0x00. Repeat after 5 writes -> FIFO reports empty again.
- Basic: write 0xA5, then rd_en for one cycle -> empty goes 1->0->1; rdata=0xA5 one cycle after the read edge.
- Fill: write 0x00..0x0F (16 writes) -> full=1 after the 16th edge. A 17th write of 0xFF is dropped. 16 reads return 0x00..0x0F in order; empty=1 after the last read.
- Underflow: rd_en on empty FIFO holding last rdata=0x0F -> rdata stays 0x0F, pointers and flags unchanged.
- Simultaneous: with 3 entries held, assert wr_en and rd_en for 10 cycles with incrementing data -> occupancy stays 3, flags static, output order intact. Repeat from empty (write only) and from full (read only).
- Wrap and random: 200 cycles of random wr_en/rd_en/wdata, compared against a queue model -> rdata matches on every accepted read, flags match model occupancy, and the pointers wrap at least 3 times.
